crc_checker_multi: RTL and testbench
====================================

# crc_checker_multi

Serial, runtime-selectable CRC5/CRC16 checker for the USB receive path. It sits after the NRZI decoder and bit unstuffer and consumes one qualified bit per `shift_en`. It frames a packet between `clear` (start) and `eop` (end). At end of packet it reports a one-cycle verdict with residual-compare and short-packet detection. Polynomials, seeds, residuals and the bit-counter width are parameters.

## Interface
- `CRC16_POLY`, 16'h8005, CRC16 generator polynomial (x^16 term implicit).
- `CRC16_INIT`, 16'hFFFF, CRC16 seed loaded on `clear`.
- `CRC16_RESID`, 16'h800D, CRC16 good-packet residual.
- `CRC5_POLY`, 5'h05, CRC5 generator polynomial (x^5 term implicit).
- `CRC5_INIT`, 5'h1F, CRC5 seed.
- `CRC5_RESID`, 5'h0C, CRC5 good-packet residual.
- `CNT_W`, 11, width of the saturating bit counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `nRst`  in  1  asynchronous active-low reset.
- `din`  in  1  unstuffed serial data bit, LSB-first.
- `shift_en`  in  1  `din` is valid this cycle.
- `clear`  in  1  start of packet; reseeds and arms the checker.
- `mode16`  in  1  1 selects CRC16, 0 selects CRC5; sampled only when `clear` is high.
- `eop`  in  1  end of packet; the bit on the same cycle is included if `shift_en` is high.
- `busy`  out  1  high while in RUN.
- `crc_valid`  out  1  one-cycle verdict strobe.
- `crc_error`  out  1  verdict; held until the next `clear`.
- `short_pkt`  out  1  fewer bits than the CRC width were received; held until the next `clear`.
- `crc_value`  out  16  live LFSR contents; bits 15:5 read 0 in CRC5 mode.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with the LFSR, counter, `busy`, `crc_valid`, `crc_error` and `short_pkt` all 0, and the latched mode at 0.
- `clear` has highest priority and acts in any state:
  - next state RUN;
  - LFSR loads the seed for `mode16`; mode is latched;
  - counter goes to 0;
  - `crc_error`, `short_pkt` and `crc_valid` go to 0;
  - `din`, `shift_en` and `eop` in the same cycle are ignored.
- LFSR update in RUN with `shift_en`=1 (Galois form, W = 16 or 5):
  - fb = `din` ^ lfsr[W-1];
  - lfsr <= {lfsr[W-2:0], 0} ^ (fb ? POLY : 0);
  - counter increments and saturates at 2^CNT_W-1.
- In CRC5 mode only bits 4:0 update; bits 15:5 stay 0.
- `eop` in RUN:
  - the next LFSR value and next count are used, so a final bit on the `eop` cycle is included;
  - short = next count < W;
  - error = short | (next lfsr[W-1:0] != RESID);
  - these are registered into `short_pkt` and `crc_error`, `crc_valid` is set, and the state goes to DONE.
- DONE lasts exactly one cycle, then IDLE. `crc_valid` is high only in DONE.
- In IDLE and DONE, `shift_en` and `eop` are ignored, and the LFSR and counter hold.
- Reset asserted mid-packet aborts immediately to reset values. No verdict is produced.

## Timing
- A bit sampled at edge k is reflected in `crc_value` after edge k.
- `eop` sampled at edge k: `crc_valid`, `crc_error` and `short_pkt` are valid after edge k, and `crc_valid` drops after edge k+1.
- `busy` rises the cycle after `clear` and falls together with `crc_valid` rising.
- `clear` back-to-back with `eop`: `clear` wins, and no verdict is produced.
- `clear` during DONE: `crc_valid` lasts only that cycle, and the verdict outputs clear on the next edge.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset with `nRst`=0 mid-stream -> all outputs 0 and `busy`=0 immediately (asynchronous), and still 0 after release.
- CRC16, zero-length DATA payload: `clear` with `mode16`=1, then 16 zero bits with `eop` on the 16th -> `crc_value`=16'h800D, one-cycle `crc_valid`, `crc_error`=0, `short_pkt`=0.
- Same as above with bit 7 flipped to 1 -> `crc_valid` pulses, `crc_error`=1, `short_pkt`=0.
- CRC5, SETUP token to addr 0 / ep 0: `clear` with `mode16`=0, then 11 zeros followed by 0,1,0,0,0 -> `crc_value`=5'h0C, `crc_error`=0.
- Short packet: CRC16 mode, `eop` after 10 bits -> `crc_error`=1, `short_pkt`=1.
- Gaps and priority:
  - `shift_en` gaps of 1–3 cycles inside the CRC16 zero-payload case -> still `crc_error`=0.
  - `clear` asserted on the same cycle as `eop` -> no `crc_valid`; the block is in RUN with `crc_value`=16'hFFFF.

Source files
------------

// File: rtl/crc_checker_multi.sv
// Serial CRC5/CRC16 checker for the USB receive path.
// Frames a packet between clear and eop and emits a one-cycle verdict.
module crc_checker_multi #(
  parameter logic [15:0] CRC16_POLY  = 16'h8005,
  parameter logic [15:0] CRC16_INIT  = 16'hFFFF,
  parameter logic [15:0] CRC16_RESID = 16'h800D,
  parameter logic [4:0]  CRC5_POLY   = 5'h05,
  parameter logic [4:0]  CRC5_INIT   = 5'h1F,
  parameter logic [4:0]  CRC5_RESID  = 5'h0C,
  parameter int          CNT_W       = 11
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        din,
  input  logic        shift_en,
  input  logic        clear,
  input  logic        mode16,
  input  logic        eop,
  output logic        busy,
  output logic        crc_valid,
  output logic        crc_error,
  output logic        short_pkt,
  output logic [15:0] crc_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] W16 = CNT_W'(16);
  localparam logic [CNT_W-1:0] W5  = CNT_W'(5);

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             short_q, short_d;

  logic             fb16, fb5;
  logic [15:0]      step16;
  logic [4:0]       step5;
  logic [15:0]      lfsr_n;
  logic [CNT_W-1:0] cnt_inc, cnt_n;
  logic             short_n, bad_n;

  assign fb16   = din ^ lfsr_q[15];
  assign fb5    = din ^ lfsr_q[4];
  assign step16 = {lfsr_q[14:0], 1'b0}
                ^ (fb16 ? CRC16_POLY : 16'h0000);
  assign step5  = {lfsr_q[3:0], 1'b0}
                ^ (fb5 ? CRC5_POLY : 5'h00);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Candidate next LFSR/count for a RUN cycle, so eop sees the last bit
  always_comb begin
    lfsr_n = lfsr_q;
    cnt_n  = cnt_q;
    if (shift_en) begin
      lfsr_n = mode_q ? step16 : {11'h000, step5};
      cnt_n  = cnt_inc;
    end
  end

  assign short_n = mode_q ? (cnt_n < W16) : (cnt_n < W5);
  assign bad_n   = mode_q ? (lfsr_n != CRC16_RESID)
                          : (lfsr_n[4:0] != CRC5_RESID);

  // Next-state logic; clear overrides everything in any state
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    short_d = short_q;
    if (clear) begin
      state_d = RUN;
      mode_d  = mode16;
      lfsr_d  = mode16 ? CRC16_INIT : {11'h000, CRC5_INIT};
      cnt_d   = '0;
      err_d   = 1'b0;
      short_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          lfsr_d = lfsr_n;
          cnt_d  = cnt_n;
          if (eop) begin
            short_d = short_n;
            err_d   = short_n | bad_n;
            state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      short_q <= short_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign crc_valid = (state_q == DONE);
  assign crc_error = err_q;
  assign short_pkt = short_q;
  assign crc_value = lfsr_q;

endmodule

// File: tb/tb_crc_checker_multi.sv
// Randomized self-checking bench for crc_checker_multi.
// A bit-list CRC model predicts every value and verdict.
module tb_crc_checker_multi;

  logic        clk = 1'b0;
  logic        nRst;
  logic        din;
  logic        shift_en;
  logic        clear;
  logic        mode16;
  logic        eop;
  logic        busy;
  logic        crc_valid;
  logic        crc_error;
  logic        short_pkt;
  logic [15:0] crc_value;

  int n_chk  = 0;
  int n_fail = 0;
  bit pkt[$];

  crc_checker_multi dut (
    .clk(clk), .nRst(nRst), .din(din),
    .shift_en(shift_en), .clear(clear),
    .mode16(mode16), .eop(eop), .busy(busy),
    .crc_valid(crc_valid), .crc_error(crc_error),
    .short_pkt(short_pkt), .crc_value(crc_value)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int seed_of(input bit m);
    return m ? 32'hFFFF : 32'h1F;
  endfunction

  // Polynomial long division of the bit stream, one bit at a time
  function automatic int model_step(input bit m, input int v, input bit b);
    int w    = m ? 16 : 5;
    int poly = m ? 32'h8005 : 32'h05;
    int mask = (1 << w) - 1;
    int top  = (v >> (w - 1)) & 1;
    int nv   = (v << 1) & mask;
    if ((top ^ int'(b)) != 0) nv = nv ^ poly;
    return nv;
  endfunction

  // Frame pkt[] as one packet and check every step plus the verdict
  task automatic send_pkt(input bit m, input int maxgap, input string nm);
    int w     = m ? 16 : 5;
    int resid = m ? 32'h800D : 32'h0C;
    int v     = seed_of(m);
    int cnt   = 0;
    bit exp_s, exp_e;
    clear = 1; mode16 = m; eop = $urandom_range(0, 1);
    shift_en = $urandom_range(0, 1); din = $urandom_range(0, 1);
    cyc();
    clear = 0; shift_en = 0; eop = 0;
    n_chk++;
    if (busy !== 1'b1 || crc_valid !== 1'b0 || crc_value !== 16'(v)) begin
      n_fail++;
      $display("FAIL %s_armed busy=%b valid=%b crc=%h want busy=1 valid=0 crc=%h",
               nm, busy, crc_valid, crc_value, 16'(v));
    end
    if (pkt.size() == 0) begin
      eop = 1; cyc(); eop = 0;
    end
    for (int i = 0; i < pkt.size(); i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        shift_en = 0; din = $urandom_range(0, 1); cyc();
      end
      shift_en = 1; din = pkt[i]; eop = (i == pkt.size() - 1);
      cyc();
      v = model_step(m, v, pkt[i]);
      cnt++;
      if (i != pkt.size() - 1) begin
        n_chk++;
        if (crc_value !== 16'(v) || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_bit%0d crc=%h busy=%b want crc=%h busy=1",
                   nm, i, crc_value, busy, 16'(v));
        end
      end
    end
    shift_en = 0; eop = 0;
    exp_s = (cnt < w);
    exp_e = exp_s || (v != resid);
    n_chk++;
    if (crc_valid !== 1'b1 || busy !== 1'b0 || crc_error !== exp_e
        || short_pkt !== exp_s || crc_value !== 16'(v)) begin
      n_fail++;
      $display("FAIL %s_verdict valid=%b busy=%b err=%b short=%b crc=%h want 1 0 %b %b %h",
               nm, crc_valid, busy, crc_error, short_pkt, crc_value,
               exp_e, exp_s, 16'(v));
    end
    shift_en = 1; din = $urandom_range(0, 1); eop = 1;
    cyc();
    shift_en = 1; din = 1; eop = 1;
    cyc();
    shift_en = 0; eop = 0;
    n_chk++;
    if (crc_valid !== 1'b0 || busy !== 1'b0 || crc_error !== exp_e
        || short_pkt !== exp_s || crc_value !== 16'(v)) begin
      n_fail++;
      $display("FAIL %s_hold valid=%b busy=%b err=%b short=%b crc=%h want 0 0 %b %b %h",
               nm, crc_valid, busy, crc_error, short_pkt, crc_value,
               exp_e, exp_s, 16'(v));
    end
  endtask

  task automatic test_reset();
    nRst = 0; din = 0; shift_en = 0; clear = 0; mode16 = 0; eop = 0;
    #3;
    n_chk++;
    if ({busy, crc_valid, crc_error, short_pkt} !== 4'b0 || crc_value !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state flags=%b crc=%h want 0000 0000",
               {busy, crc_valid, crc_error, short_pkt}, crc_value);
    end
    repeat (2) cyc();
    nRst = 1;
    cyc();
  endtask

  task automatic test_crc16_zero();
    pkt.delete();
    repeat (16) pkt.push_back(1'b0);
    send_pkt(1'b1, 0, "crc16_zero");
    n_chk++;
    if (crc_value !== 16'h800D || crc_error !== 1'b0) begin
      n_fail++;
      $display("FAIL crc16_zero_const crc=%h err=%b want 800d 0", crc_value, crc_error);
    end
  endtask

  task automatic test_crc16_flip();
    pkt.delete();
    repeat (16) pkt.push_back(1'b0);
    pkt[7] = 1'b1;
    send_pkt(1'b1, 0, "crc16_flip");
    n_chk++;
    if (crc_error !== 1'b1 || short_pkt !== 1'b0) begin
      n_fail++;
      $display("FAIL crc16_flip_const err=%b short=%b want 1 0", crc_error, short_pkt);
    end
  endtask

  task automatic test_crc5_setup();
    pkt.delete();
    repeat (11) pkt.push_back(1'b0);
    pkt.push_back(1'b0); pkt.push_back(1'b1);
    pkt.push_back(1'b0); pkt.push_back(1'b0); pkt.push_back(1'b0);
    send_pkt(1'b0, 0, "crc5_setup");
    n_chk++;
    if (crc_value !== 16'h000C || crc_error !== 1'b0) begin
      n_fail++;
      $display("FAIL crc5_setup_const crc=%h err=%b want 000c 0", crc_value, crc_error);
    end
  endtask

  task automatic test_short();
    pkt.delete();
    repeat (10) pkt.push_back(1'($urandom_range(0, 1)));
    send_pkt(1'b1, 0, "short16");
    n_chk++;
    if (crc_error !== 1'b1 || short_pkt !== 1'b1) begin
      n_fail++;
      $display("FAIL short16_const err=%b short=%b want 1 1", crc_error, short_pkt);
    end
    pkt.delete();
    repeat (4) pkt.push_back(1'($urandom_range(0, 1)));
    send_pkt(1'b0, 0, "short5");
    pkt.delete();
    send_pkt(1'b1, 0, "empty16");
  endtask

  task automatic test_reset_mid();
    nRst = 0;
    #2;
    n_chk++;
    if ({busy, crc_valid, crc_error, short_pkt} !== 4'b0 || crc_value !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_idle flags=%b crc=%h want 0000 0000",
               {busy, crc_valid, crc_error, short_pkt}, crc_value);
    end
    nRst = 1;
    cyc();
    clear = 1; mode16 = 1; cyc(); clear = 0;
    shift_en = 1;
    for (int i = 0; i < 5; i++) begin
      din = 1'($urandom_range(0, 1)); cyc();
    end
    shift_en = 0;
    #2;
    nRst = 0;
    #1;
    n_chk++;
    if ({busy, crc_valid, crc_error, short_pkt} !== 4'b0 || crc_value !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_async flags=%b crc=%h want 0000 0000",
               {busy, crc_valid, crc_error, short_pkt}, crc_value);
    end
    cyc();
    nRst = 1;
    shift_en = 1; eop = 1;
    repeat (2) cyc();
    shift_en = 0; eop = 0;
    n_chk++;
    if ({busy, crc_valid, crc_error, short_pkt} !== 4'b0 || crc_value !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_release flags=%b crc=%h want 0000 0000",
               {busy, crc_valid, crc_error, short_pkt}, crc_value);
    end
  endtask

  task automatic test_gaps();
    pkt.delete();
    repeat (16) pkt.push_back(1'b0);
    send_pkt(1'b1, 3, "gaps16");
    n_chk++;
    if (crc_error !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps16_const err=%b want 0", crc_error);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      bit m = 1'($urandom_range(0, 1));
      int n = $urandom_range(0, 40);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(1'($urandom_range(0, 1)));
      send_pkt(m, $urandom_range(0, 2), $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_clear_eop();
    clear = 1; mode16 = 1; cyc(); clear = 0;
    shift_en = 1;
    for (int i = 0; i < 6; i++) begin
      din = 1'($urandom_range(0, 1)); cyc();
    end
    clear = 1; mode16 = 1; eop = 1; din = 1; shift_en = 1;
    cyc();
    clear = 0; eop = 0; shift_en = 0;
    n_chk++;
    if (crc_valid !== 1'b0 || busy !== 1'b1 || crc_value !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL clear_eop valid=%b busy=%b crc=%h want 0 1 ffff",
               crc_valid, busy, crc_value);
    end
    cyc();
    n_chk++;
    if (crc_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_eop_next valid=%b busy=%b want 0 1", crc_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    pkt.delete();
    repeat (16) pkt.push_back(1'b0);
    pkt[3] = 1'b1;
    clear = 1; mode16 = 1; cyc(); clear = 0;
    for (int i = 0; i < 16; i++) begin
      shift_en = 1; din = pkt[i]; eop = (i == 15); cyc();
    end
    shift_en = 0; eop = 0;
    n_chk++;
    if (crc_valid !== 1'b1 || crc_error !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_verdict valid=%b err=%b want 1 1", crc_valid, crc_error);
    end
    clear = 1; mode16 = 0; cyc(); clear = 0;
    n_chk++;
    if (crc_valid !== 1'b0 || crc_error !== 1'b0 || short_pkt !== 1'b0
        || busy !== 1'b1 || crc_value !== 16'h001F) begin
      n_fail++;
      $display("FAIL b2b_clear valid=%b err=%b short=%b busy=%b crc=%h want 0 0 0 1 001f",
               crc_valid, crc_error, short_pkt, busy, crc_value);
    end
    pkt.delete();
    repeat (11) pkt.push_back(1'b0);
    pkt.push_back(1'b0); pkt.push_back(1'b1);
    pkt.push_back(1'b0); pkt.push_back(1'b0); pkt.push_back(1'b0);
    send_pkt(1'b0, 1, "b2b_crc5");
  endtask

  initial begin
    test_reset();
    test_crc16_zero();
    test_crc16_flip();
    test_crc5_setup();
    test_short();
    test_reset_mid();
    test_gaps();
    test_clear_eop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
